inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch queue between the instruction cache output and the dual-issue decode stage. Buffers fetched {pc, inst} pairs one per cycle from the fetch pipeline and presents up to two oldest entries to decode, which retires 0, 1 or 2 per cycle. Decouples decode back-pressure from the cache pipeline and discards all buffered instructions on a redirect (`flush`).

## Interface

Parameters:
- `DEPTH`, 8: number of entries. Power of two, ≥4.
- `PC_W`, 32: pc width.
- `INST_W`, 32: instruction width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `flush`, in, 1: pipeline redirect; empties the queue.
- `in_valid`, in, 1: fetch presents a valid instruction.
- `in_pc`, in, PC_W: pc of the pushed instruction.
- `in_inst`, in, INST_W: pushed instruction word.
- `in_ready`, out, 1: queue can accept a push this cycle.
- `out0_valid`, out, 1: head entry valid.
- `out0_pc`, out, PC_W: head pc.
- `out0_inst`, out, INST_W: head instruction.
- `out1_valid`, out, 1: second entry valid.
- `out1_pc`, out, PC_W: second entry pc.
- `out1_inst`, out, INST_W: second entry instruction.
- `out_pop`, in, 2: number of entries decode consumes this cycle (0, 1, 2; 3 is treated as 2).
- `count`, out, log2(DEPTH)+1: current occupancy.

## Operation

- Storage: DEPTH-entry register array of {pc, inst}. Read pointer `rp` and write pointer `wp` are log2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate register.
- Push: accepted when `in_valid & in_ready`. The entry is written at `wp`, and `wp` increments.
- `in_ready = (count != DEPTH)`. It depends only on registered state. A same-cycle pop does not enable a push into a full queue.
- Pop: effective pop `n = min(out_pop clamped to 2, count)`. Then `rp += n`. Popping more than is valid is clamped and is not an error.
- Count update: `count_next = count + push - n`.
- Outputs:
  - `out0_valid = (count >= 1)`.
  - `out1_valid = (count >= 2)`.
  - `out0` shows entry `rp`; `out1` shows entry `(rp+1) mod DEPTH`.
  - When a valid flag is low, its pc and inst are driven to 0.
  - Outputs are combinational from registers only; there is no path from `in_*` or `out_pop` to outputs.
- Flush: highest priority after `rst`. On a cycle with `flush=1`, `rp`, `wp` and `count` are set to 0. A same-cycle push and pop are discarded. Storage contents are not cleared.
- Reset: same effect as flush. Additionally, every storage entry is cleared to 0.
- There is no bypass. An instruction pushed at edge t is visible on `out0` only from the cycle after edge t.

## Timing

- Reset values: `in_ready=1`, `out0_valid=0`, `out1_valid=0`, all `out*_pc` and `out*_inst` = 0, `count=0`.
- Push-to-visible latency: 1 cycle.
- Pop takes effect at the clock edge. The next head is visible in the following cycle.
- Throughput: sustained 1 push per cycle, up to 2 pops per cycle.
- Full (`count=DEPTH`): `in_ready=0`. A push presented that cycle is not accepted, and fetch must hold it. `in_ready` returns to 1 in the cycle after any pop.
- Empty: both valids are 0. `out_pop` is ignored. A simultaneous push sets `count=1`.
- Count=1 with `out_pop=2`: one entry is popped. With a simultaneous push, `count` stays 1 and the new entry becomes the head.
- Wrap-around: pointers roll from DEPTH-1 to 0 without bubbles. `out1` of entry DEPTH-1 reads entry 0.
- `flush` held for several cycles: the queue stays empty and `in_ready=1` throughout.
- `rst` or `flush` asserted mid-stream: the queue is empty on the next cycle regardless of push/pop that cycle.

## Test plan

- Reset, then push pc 0x1000/inst 0x24010001 for one cycle with `out_pop=0`. Next cycle: `out0_valid=1`, `out0_pc=0x1000`, `out0_inst=0x24010001`, `out1_valid=0`, `count=1`.
- Push 8 instructions with pcs 0x1000..0x101C and no pops. Afterwards `count=8` and `in_ready=0`. A 9th push with pc 0x1020 held for 3 cycles is not accepted. Then pop 1: `in_ready=1` next cycle, the 0x1020 push is accepted, and `out0_pc=0x1004`.
- Fill 4 entries, then pop 2 per cycle while pushing 1 per cycle for 12 cycles. Pcs appear strictly in order across the pointer wrap. `count` decreases by 1 per cycle until empty, then pops are clamped and `count` stays within 0..1.
- With `count=1` (pc 0x2000), assert push 0x2004 and `out_pop=2` together. Next cycle: `count=1`, `out0_pc=0x2004`, `out1_valid=0`.
- With `count=5`, assert `flush` together with a push and `out_pop=1`. Next cycle: `count=0`, both valids 0, `in_ready=1`, and pc/inst outputs are 0. The following push appears as the head.
- Assert `rst` in the middle of random push/pop traffic. Next cycle all outputs are at their reset values. A scoreboard run of 1000 random cycles (random `in_valid`, `out_pop`, `flush`) matches a reference queue model every cycle.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between fetch, the instruction fetch queue and dual-issue decode.
// The master side is the fetch/decode pair; the slave side is the queue itself.
interface inst_fetch_queue_if #(
   parameter int DEPTH  = 8,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   logic                     flush;
   logic                     in_valid;
   logic [PC_W-1:0]          in_pc;
   logic [INST_W-1:0]        in_inst;
   logic                     in_ready;
   logic                     out0_valid;
   logic [PC_W-1:0]          out0_pc;
   logic [INST_W-1:0]        out0_inst;
   logic                     out1_valid;
   logic [PC_W-1:0]          out1_pc;
   logic [INST_W-1:0]        out1_inst;
   logic [1:0]               out_pop;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output flush, in_valid, in_pc, in_inst, out_pop,
      input  in_ready, out0_valid, out0_pc, out0_inst,
             out1_valid, out1_pc, out1_inst, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_pop,
      output in_ready, out0_valid, out0_pc, out0_inst,
             out1_valid, out1_pc, out1_inst, count
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one push per cycle from fetch, up to two in-order pops per
// cycle to dual-issue decode, emptied by a redirect flush. No push-to-output bypass.
module inst_fetch_queue #(
   parameter int DEPTH  = 8,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   inst_fetch_queue_if.slave   q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PC_W-1:0]   pc_mem_r   [DEPTH];
   logic [INST_W-1:0] inst_mem_r [DEPTH];
   logic [PTR_W-1:0]  rp_r;
   logic [PTR_W-1:0]  wp_r;
   logic [PTR_W-1:0]  rp1_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic [CNT_W-1:0]  pop_req_s;
   logic [CNT_W-1:0]  pop_n_s;
   logic              ready_s;
   logic              push_s;

   // Accept/retire decisions; in_ready comes from registered occupancy only.
   always_comb begin
      ready_s = (count_r != CNT_FULL);
      push_s  = q.in_valid & ready_s;
      case (q.out_pop)
         2'd0:    pop_req_s = CNT_ZERO;
         2'd1:    pop_req_s = CNT_W'(1);
         default: pop_req_s = CNT_TWO;
      endcase
      if (pop_req_s > count_r) begin
         pop_n_s = count_r;
      end else begin
         pop_n_s = pop_req_s;
      end
      count_next_s = count_r + {{(CNT_W-1){1'b0}}, push_s} - pop_n_s;
      rp1_s        = rp_r + PTR_W'(1);
   end

   // Pointer and occupancy state; flush wins over any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rp_r    <= {PTR_W{1'b0}};
         wp_r    <= {PTR_W{1'b0}};
         count_r <= CNT_ZERO;
      end else if (q.flush) begin
         rp_r    <= {PTR_W{1'b0}};
         wp_r    <= {PTR_W{1'b0}};
         count_r <= CNT_ZERO;
      end else begin
         rp_r    <= rp_r + pop_n_s[PTR_W-1:0];
         wp_r    <= wp_r + {{(PTR_W-1){1'b0}}, push_s};
         count_r <= count_next_s;
      end
   end

   // Entry storage; only reset clears it, a flush just abandons the contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= {PC_W{1'b0}};
            inst_mem_r[i] <= {INST_W{1'b0}};
         end
      end else if (push_s & ~q.flush) begin
         pc_mem_r[wp_r]   <= q.in_pc;
         inst_mem_r[wp_r] <= q.in_inst;
      end
   end

   // Head and second-entry views, zeroed whenever the slot is not valid.
   always_comb begin
      q.in_ready   = ready_s;
      q.count      = count_r;
      q.out0_valid = (count_r != CNT_ZERO);
      q.out1_valid = (count_r >= CNT_TWO);
      if (q.out0_valid) begin
         q.out0_pc   = pc_mem_r[rp_r];
         q.out0_inst = inst_mem_r[rp_r];
      end else begin
         q.out0_pc   = {PC_W{1'b0}};
         q.out0_inst = {INST_W{1'b0}};
      end
      if (q.out1_valid) begin
         q.out1_pc   = pc_mem_r[rp1_s];
         q.out1_inst = inst_mem_r[rp1_s];
      end else begin
         q.out1_pc   = {PC_W{1'b0}};
         q.out1_inst = {INST_W{1'b0}};
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: hand-computed vector table, directed corner
// sequences, and a reference queue model compared against every output each cycle.
module tb_inst_fetch_queue;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  pop;
      logic        fl;
      logic [3:0]  cnt;
      logic        rdy;
      logic        v0;
      logic [31:0] pc0;
      logic        v1;
      logic [31:0] pc1;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   ent_t mq[$];
   vec_t vecs[11];

   always #5 clk = ~clk;

   inst_fetch_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus();

   inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return (pc * 32'h0000_9E37) ^ 32'h0000_0013;
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference queue: pops computed from pre-push occupancy, push only when not full.
   task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [1:0] pop, input logic fl, input logic r);
      int sz;
      int req;
      int n;
      if (r || fl) begin
         mq.delete();
      end else begin
         sz  = mq.size();
         req = (pop == 2'd3) ? 2 : int'(pop);
         n   = (req < sz) ? req : sz;
         repeat (n) void'(mq.pop_front());
         if (v && sz < DEPTH) mq.push_back({pc, inst});
      end
   endtask

   task automatic check_model();
      ent_t h0;
      ent_t h1;
      h0 = (mq.size() >= 1) ? mq[0] : 64'h0;
      h1 = (mq.size() >= 2) ? mq[1] : 64'h0;
      check_val("count",      32'(bus.count),      32'(mq.size()));
      check_val("in_ready",   32'(bus.in_ready),   32'(mq.size() < DEPTH));
      check_val("out0_valid", 32'(bus.out0_valid), 32'(mq.size() >= 1));
      check_val("out0_pc",    bus.out0_pc,         h0.pc);
      check_val("out0_inst",  bus.out0_inst,       h0.inst);
      check_val("out1_valid", 32'(bus.out1_valid), 32'(mq.size() >= 2));
      check_val("out1_pc",    bus.out1_pc,         h1.pc);
      check_val("out1_inst",  bus.out1_inst,       h1.inst);
   endtask

   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [1:0] pop, input logic fl, input logic r);
      bus.in_valid = v;
      bus.in_pc    = pc;
      bus.in_inst  = inst;
      bus.out_pop  = pop;
      bus.flush    = fl;
      rst          = r;
      model_step(v, pc, inst, pop, fl, r);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic push(input logic [31:0] pc, input logic [1:0] pop);
      cycle(1'b1, pc, inst_of(pc), pop, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic [1:0] pop);
      cycle(1'b0, 32'h0, 32'h0, pop, 1'b0, 1'b0);
   endtask

   initial begin
      logic        rv;
      logic [1:0]  rpop;
      logic        rfl;
      logic [31:0] rpc;

      vecs[0]  = '{1'b1, 32'h1000, 32'h2401_0001, 2'd0, 1'b0, 4'd1, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 32'h1004, 32'h2401_0002, 2'd0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h1000, 1'b1, 32'h1004};
      vecs[2]  = '{1'b0, 32'h0,    32'h0,         2'd3, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'h0,    32'h0,         2'd2, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
      vecs[4]  = '{1'b1, 32'h2000, 32'hAAAA_0000, 2'd2, 1'b0, 4'd1, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 32'h2004, 32'hAAAA_0004, 2'd2, 1'b0, 4'd1, 1'b1, 1'b1, 32'h2004, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 32'h2008, 32'hAAAA_0008, 2'd0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h2004, 1'b1, 32'h2008};
      vecs[7]  = '{1'b1, 32'h200C, 32'hAAAA_000C, 2'd1, 1'b0, 4'd2, 1'b1, 1'b1, 32'h2008, 1'b1, 32'h200C};
      vecs[8]  = '{1'b1, 32'h2010, 32'hAAAA_0010, 2'd0, 1'b1, 4'd0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
      vecs[9]  = '{1'b1, 32'h3000, 32'hBBBB_0000, 2'd1, 1'b0, 4'd1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'h0,    32'h0,         2'd1, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};

      cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
      check_val("rst_count", 32'(bus.count), 32'd0);
      check_val("rst_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].pop, vecs[i].fl, 1'b0);
         check_val($sformatf("vec%0d_cnt", i), 32'(bus.count),      32'(vecs[i].cnt));
         check_val($sformatf("vec%0d_rdy", i), 32'(bus.in_ready),   32'(vecs[i].rdy));
         check_val($sformatf("vec%0d_v0", i),  32'(bus.out0_valid), 32'(vecs[i].v0));
         check_val($sformatf("vec%0d_pc0", i), bus.out0_pc,         vecs[i].pc0);
         check_val($sformatf("vec%0d_v1", i),  32'(bus.out1_valid), 32'(vecs[i].v1));
         check_val($sformatf("vec%0d_pc1", i), bus.out1_pc,         vecs[i].pc1);
      end
      check_val("vec0_inst_path", 32'(vecs[0].inst), 32'h2401_0001);

      // Full queue: held ninth push is refused until a pop frees a slot.
      for (int i = 0; i < 8; i++) push(32'h1000 + 32'(4 * i), 2'd0);
      check_val("full_count", 32'(bus.count), 32'd8);
      check_val("full_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         push(32'h1020, 2'd0);
         check_val("full_hold_count", 32'(bus.count), 32'd8);
      end
      push(32'h1020, 2'd1);
      check_val("full_pop_ready", 32'(bus.in_ready), 32'd1);
      check_val("full_pop_pc0", bus.out0_pc, 32'h1004);
      push(32'h1020, 2'd0);
      check_val("full_accept_count", 32'(bus.count), 32'd8);

      // Drain two per cycle against one push per cycle across the pointer wrap.
      cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) push(32'h4000 + 32'(4 * i), 2'd0);
      for (int k = 1; k <= 12; k++) begin
         push(32'h4010 + 32'(4 * (k - 1)), 2'd2);
         check_val($sformatf("drain%0d_count", k), 32'(bus.count), 32'((4 - k) > 1 ? (4 - k) : 1));
      end

      // Flush with five buffered entries and a same-cycle push and pop.
      for (int i = 0; i < 4; i++) push(32'h5000 + 32'(4 * i), 2'd0);
      check_val("pre_flush_count", 32'(bus.count), 32'd5);
      cycle(1'b1, 32'h5100, 32'h0000_5100, 2'd1, 1'b1, 1'b0);
      check_val("flush_count", 32'(bus.count), 32'd0);
      check_val("flush_pc0", bus.out0_pc, 32'h0);
      check_val("flush_inst0", bus.out0_inst, 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
      check_val("flush_hold_ready", 32'(bus.in_ready), 32'd1);
      push(32'h5200, 2'd0);
      check_val("post_flush_head", bus.out0_pc, 32'h5200);

      // Random traffic with occasional flushes and a mid-stream reset.
      for (int i = 0; i < 1000; i++) begin
         rv   = ($urandom_range(0, 3) != 0);
         rpop = (i < 500 && $urandom_range(0, 2) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
         rfl  = ($urandom_range(0, 39) == 0);
         rpc  = $urandom;
         cycle(rv, rpc, $urandom, rpop, rfl, (i == 500) ? 1'b1 : 1'b0);
         if (i == 500) begin
            check_val("midrst_count", 32'(bus.count), 32'd0);
            check_val("midrst_ready", 32'(bus.in_ready), 32'd1);
            check_val("midrst_v0", 32'(bus.out0_valid), 32'd0);
            check_val("midrst_pc1", bus.out1_pc, 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
